// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default width, FSM encoding.
// Optional signed mode is selected with the SIGNED_DIV_EN macro.
package div_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b100
   } state_t;

   function automatic int cnt_bits(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_cu.sv
// Divider control unit: one-hot FSM, iteration counter and datapath strobes.
// Macro SIGNED_DIV_EN has no effect here; latency is identical in both builds.
module div_cu
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic clk,
   input  logic resetN,
   input  logic S,
   input  logic zero_div,
   output logic load,
   output logic load_zero,
   output logic step,
   output logic last,
   output logic busy,
   output logic done
);

   localparam int CW = cnt_bits(WIDTH);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load       = 1'b0;
      load_zero  = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      unique case (1'b1)
         (state == IDLE): begin
            if (S) begin
               if (zero_div) begin
                  load_zero  = 1'b1;
                  state_next = DONE;
               end else begin
                  load       = 1'b1;
                  cnt_next   = CW'(WIDTH);
                  state_next = RUN;
               end
            end
         end
         (state == RUN): begin
            step     = 1'b1;
            cnt_next = cnt - CW'(1);
            // Final iteration: results are registered on this same edge
            if (cnt == CW'(1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         (state == DONE): begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: rtl/restoring_divider.sv
// Restoring divider datapath (A, Q, M and trial subtractor) around div_cu.
// Define SIGNED_DIV_EN for two's-complement operands, truncating toward zero.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             S,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             dbz
);

   logic load;
   logic load_zero;
   logic step;
   logic last;
   logic zero_div;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [WIDTH:0]   part;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] dd_mag;
   logic [WIDTH-1:0] dv_mag;

   assign zero_div = (divisor == '0);

   div_cu #(
      .WIDTH(WIDTH)
   ) u_cu (
      .clk      (clk),
      .resetN   (resetN),
      .S        (S),
      .zero_div (zero_div),
      .load     (load),
      .load_zero(load_zero),
      .step     (step),
      .last     (last),
      .busy     (busy),
      .done     (done)
   );

   // Shift {A,Q} left, then trial-subtract M with a borrow bit kept
   always_comb begin
      part           = {a, q[WIDTH-1]};
      {borrow, diff} = {1'b0, part} - {2'b00, m};
      a_next         = borrow ? part[WIDTH-1:0] : diff[WIDTH-1:0];
      q_next         = {q[WIDTH-2:0], ~borrow};
   end

`ifdef SIGNED_DIV_EN
   logic neg_q;
   logic neg_r;

   // Divide magnitudes; -2^(WIDTH-1) maps to itself, valid as unsigned
   always_comb begin
      dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
      dv_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
      q_res  = neg_q ? -q_next : q_next;
      r_res  = neg_r ? -a_next : a_next;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r <= dividend[WIDTH-1];
      end
   end
`else
   always_comb begin
      dd_mag = dividend;
      dv_mag = divisor;
      q_res  = q_next;
      r_res  = a_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetN) begin
         a         <= '0;
         q         <= '0;
         m         <= '0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
      end else begin
         if (load) begin
            a   <= '0;
            q   <= dd_mag;
            m   <= dv_mag;
            dbz <= 1'b0;
         end
         if (load_zero) begin
            quotient  <= '1;
            remainder <= dividend;
            dbz       <= 1'b1;
         end
         if (step) begin
            a <= a_next;
            q <= q_next;
         end
         if (last) begin
            quotient  <= q_res;
            remainder <= r_res;
         end
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8) against an arithmetic model.
// Build with SIGNED_DIV_EN defined to exercise the signed configuration.
module tb_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         resetN = 1'b0;
   logic         S = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         dbz;

   int checks = 0;
   int passed = 0;

   restoring_divider #(.WIDTH(W)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .S        (S),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (quotient),
      .remainder(remainder),
      .busy     (busy),
      .done     (done),
      .dbz      (dbz)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division from the operand rules
   task automatic model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        output logic [W-1:0] eq, output logic [W-1:0] er,
                        output logic ez, output int elat);
      int a;
      int b;
      int qi;
      int ri;
      if (dv == '0) begin
         eq   = '1;
         er   = dd;
         ez   = 1'b1;
         elat = 0;
      end else begin
`ifdef SIGNED_DIV_EN
         a = int'($signed(dd));
         b = int'($signed(dv));
`else
         a = int'(dd);
         b = int'(dv);
`endif
         qi   = a / b;
         ri   = a % b;
         eq   = qi[W-1:0];
         er   = ri[W-1:0];
         ez   = 1'b0;
         elat = W;
      end
   endtask

   // Stimulus only: one division from IDLE, returns results and latency
   task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output logic oz, output int lat);
      S        = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      #1;
      S        = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat      = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      oq  = quotient;
      orr = remainder;
      oz  = dbz;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      S      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (quotient !== '0) $display("FAIL reset_q got %h want 00", quotient);
      else passed++;
      checks++;
      if (remainder !== '0) $display("FAIL reset_r got %h want 00", remainder);
      else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else passed++;
      checks++;
      if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
      else passed++;
      checks++;
      if (dbz !== 1'b0) $display("FAIL reset_dbz got %b want 0", dbz);
      else passed++;
      resetN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [W-1:0] dd [5];
      logic [W-1:0] dv [5];
      logic [W-1:0] xq [5];
      logic [W-1:0] xr [5];
      logic [W-1:0] gq;
      logic [W-1:0] gr;
      logic         gz;
      int           lat;
      int           n;
      dd = '{8'd100, 8'd255, 8'd3,   8'h9C, 8'd100};
      dv = '{8'd7,   8'd1,   8'd200, 8'd7,  8'hF9};
`ifdef SIGNED_DIV_EN
      xq = '{8'd14, 8'hFF, 8'd0, 8'hF2, 8'hF2};
      xr = '{8'd2,  8'd0,  8'd3, 8'hFE, 8'h02};
      n  = 5;
`else
      xq = '{8'd14, 8'd255, 8'd0, 8'd0, 8'd0};
      xr = '{8'd2,  8'd0,   8'd3, 8'd0, 8'd0};
      n  = 3;
`endif
      for (int i = 0; i < n; i++) begin
         do_div(dd[i], dv[i], gq, gr, gz, lat);
         checks++;
         if (gq !== xq[i]) $display("FAIL dir%0d_q got %h want %h", i, gq, xq[i]);
         else passed++;
         checks++;
         if (gr !== xr[i]) $display("FAIL dir%0d_r got %h want %h", i, gr, xr[i]);
         else passed++;
         checks++;
         if (gz !== 1'b0) $display("FAIL dir%0d_dbz got %b want 0", i, gz);
         else passed++;
         checks++;
         if (lat != W) $display("FAIL dir%0d_lat got %0d want %0d", i, lat, W);
         else passed++;
      end
   endtask

   task automatic test_dbz();
      logic [W-1:0] gq;
      logic [W-1:0] gr;
      logic         gz;
      int           lat;
      do_div(8'd42, 8'd0, gq, gr, gz, lat);
      checks++;
      if (lat != 0) $display("FAIL dbz_lat got %0d want 0", lat);
      else passed++;
      checks++;
      if (gq !== 8'hFF) $display("FAIL dbz_q got %h want ff", gq);
      else passed++;
      checks++;
      if (gr !== 8'd42) $display("FAIL dbz_r got %h want 2a", gr);
      else passed++;
      checks++;
      if (gz !== 1'b1) $display("FAIL dbz_flag got %b want 1", gz);
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dbz !== 1'b1 || quotient !== 8'hFF)
         $display("FAIL dbz_hold got dbz=%b q=%h want 1 ff", dbz, quotient);
      else passed++;
      do_div(8'd100, 8'd7, gq, gr, gz, lat);
      checks++;
      if (gz !== 1'b0 || gq !== 8'd14 || gr !== 8'd2)
         $display("FAIL dbz_clear got dbz=%b q=%0d r=%0d want 0 14 2", gz, gq, gr);
      else passed++;
   endtask

   task automatic test_random();
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      logic [W-1:0] gq;
      logic [W-1:0] gr;
      logic         gz;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      int           lat;
      int           elat;
      for (int i = 0; i < 60; i++) begin
         dd = W'($urandom);
         dv = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom);
         model(dd, dv, eq, er, ez, elat);
         do_div(dd, dv, gq, gr, gz, lat);
         checks++;
         if (gq !== eq || gr !== er || gz !== ez || lat != elat)
            $display("FAIL rand%0d %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                     i, dd, dv, gq, gr, gz, lat, eq, er, ez, elat);
         else passed++;
      end
   endtask

   task automatic test_s_held();
      int bc;
      int dc;
      int lat;
      bc       = 0;
      dc       = 0;
      S        = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (busy) bc++;
         if (done) dc++;
      end
      checks++;
      if (bc != W) $display("FAIL held_busy got %0d want %0d", bc, W);
      else passed++;
      checks++;
      if (dc != 1) $display("FAIL held_done got %0d want 1", dc);
      else passed++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL held_idle got busy=%b done=%b want 0 0", busy, done);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) $display("FAIL held_restart got %b want 1", busy);
      else passed++;
      S   = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (quotient !== 8'd14 || remainder !== 8'd2)
         $display("FAIL held_result got %0d r %0d want 14 r 2", quotient, remainder);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] gq;
      logic [W-1:0] gr;
      logic         gz;
      int           lat;
      S        = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      S = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetN = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 ||
          done !== 1'b0 || dbz !== 1'b0)
         $display("FAIL midreset got q=%h r=%h b=%b d=%b z=%b want all 0",
                  quotient, remainder, busy, done, dbz);
      else passed++;
      resetN = 1'b1;
      do_div(8'd100, 8'd7, gq, gr, gz, lat);
      checks++;
      if (gq !== 8'd14 || gr !== 8'd2 || lat != W)
         $display("FAIL midreset_div got q=%0d r=%0d lat=%0d want 14 2 %0d",
                  gq, gr, lat, W);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_dbz();
      test_random();
      test_s_held();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
